// File: rtl/sccb_seq_pkg.sv
// Shared definitions for the SCCB register-table sequencer: FSM states,
// i2c_module register map and table-word field positions.
package sccb_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_SLV,
        ST_LD_REG,
        ST_LD_DAT,
        ST_GO,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_NEXT,
        ST_DELAY,
        ST_DONE,
        ST_FAIL
    } state_e;

    localparam logic [2:0] CONTROL_REG       = 3'd0;
    localparam logic [2:0] SLAVE_ADDRESS     = 3'd1;
    localparam logic [2:0] SLAVE_REG_ADDRESS = 3'd2;
    localparam logic [2:0] SLAVE_DATA_1      = 3'd3;
    localparam logic [7:0] CTRL_GO           = 8'h01;

    localparam int unsigned DELAY_BIT = 16;
    localparam int unsigned REG_HI    = 15;
    localparam int unsigned REG_LO    = 8;
    localparam int unsigned DAT_HI    = 7;
    localparam int unsigned DAT_LO    = 0;

endpackage

// File: rtl/sccb_init_seq_if.sv
// Byte-level register interface towards i2c_module; the sequencer is the master.
interface sccb_init_seq_if;

    logic [2:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_write;
    logic       bus_ready;
    logic       bus_success;

    modport master (output bus_addr, bus_wdata, bus_write, input bus_ready, bus_success);
    modport slave  (input bus_addr, bus_wdata, bus_write, output bus_ready, bus_success);

endinterface

// File: rtl/sccb_tick_gen.sv
// Prescaler: one-clock tick every CLK_DIV clocks (CLK_DIV >= 2).
module sccb_tick_gen #(
    parameter int unsigned CLK_DIV = 256
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/sccb_init_seq.sv
// SCCB/I2C register-table sequencer driving i2c_module through a byte register bus.
// Optional watchdog on the engine wait states: define SCCB_SEQ_TIMEOUT_EN.
module sccb_init_seq
    import sccb_seq_pkg::*;
#(
    parameter int unsigned NUM_REGS      = 178,
    parameter int unsigned AW            = 8,
    parameter logic [7:0]  SLAVE_ADDR    = 8'h60,
    parameter int unsigned CLK_DIV       = 256,
    parameter int unsigned MS_TICKS      = 195,
    parameter int unsigned RETRY_MAX     = 3,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned RESTART_IDX   = 3,
    parameter int unsigned TIMEOUT_TICKS = 1024
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    output logic [AW-1:0]  tbl_idx,
    input  logic [16:0]    tbl_data,
    sccb_init_seq_if.master bus,
    output logic           ready,
    output logic           busy,
    output logic           error,
    output logic [AW-1:0]  err_idx
);

    localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] RESTART     = AW'(RESTART_IDX);
    localparam logic [7:0]    LAST_PASS   = 8'(PASSES - 1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(RETRY_MAX);

    state_e        state_q;
    logic [AW-1:0] idx_q, err_idx_q;
    logic [3:0]    retry_q;
    logic [7:0]    pass_q;
    logic [31:0]   dly_q;
    logic [2:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          write_q, ready_q, busy_q, error_q;
    logic          tick, expired;

    sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

`ifdef SCCB_SEQ_TIMEOUT_EN
    logic [31:0] to_q;

    // Counts ticks across both wait states of one attempt; cleared on any other tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q <= '0;
        end else if (tick) begin
            if (state_q == ST_WAIT_LO || state_q == ST_WAIT_HI) begin
                if (to_q != '1) to_q <= to_q + 1'b1;
            end else begin
                to_q <= '0;
            end
        end
    end

    assign expired = (to_q >= 32'(TIMEOUT_TICKS - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_TICKS;
    assign expired        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            err_idx_q <= '0;
            retry_q   <= '0;
            pass_q    <= '0;
            dly_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            write_q <= 1'b0;
            ready_q <= (state_q == ST_DONE);
            busy_q  <= !(state_q inside {ST_IDLE, ST_DONE, ST_FAIL});
            error_q <= (state_q == ST_FAIL);
            if (start && (state_q == ST_DONE || state_q == ST_FAIL)) begin
                idx_q     <= '0;
                pass_q    <= '0;
                retry_q   <= '0;
                err_idx_q <= '0;
                state_q   <= ST_IDLE;
            end else if (tick) begin
                case (state_q)
                    ST_IDLE: state_q <= ST_LD_SLV;
                    ST_LD_SLV: begin
                        if (tbl_data[DELAY_BIT]) begin
                            dly_q   <= 32'(tbl_data[REG_HI:DAT_LO]) * 32'(MS_TICKS);
                            state_q <= ST_DELAY;
                        end else begin
                            write_q <= 1'b1;
                            addr_q  <= SLAVE_ADDRESS;
                            wdata_q <= SLAVE_ADDR;
                            state_q <= ST_LD_REG;
                        end
                    end
                    ST_LD_REG: begin
                        write_q <= 1'b1;
                        addr_q  <= SLAVE_REG_ADDRESS;
                        wdata_q <= tbl_data[REG_HI:REG_LO];
                        state_q <= ST_LD_DAT;
                    end
                    ST_LD_DAT: begin
                        write_q <= 1'b1;
                        addr_q  <= SLAVE_DATA_1;
                        wdata_q <= tbl_data[DAT_HI:DAT_LO];
                        state_q <= ST_GO;
                    end
                    ST_GO: begin
                        write_q <= 1'b1;
                        addr_q  <= CONTROL_REG;
                        wdata_q <= CTRL_GO;
                        state_q <= ST_WAIT_LO;
                    end
                    ST_WAIT_LO, ST_WAIT_HI: begin
                        // A real engine result wins over a simultaneous watchdog expiry.
                        if (state_q == ST_WAIT_LO && !bus.bus_ready && !expired) begin
                            state_q <= ST_WAIT_HI;
                        end else if (state_q == ST_WAIT_HI && bus.bus_ready && bus.bus_success) begin
                            state_q <= ST_NEXT;
                        end else if ((state_q == ST_WAIT_HI && bus.bus_ready) || expired) begin
                            if (retry_q < RETRY_LIMIT) begin
                                retry_q <= retry_q + 1'b1;
                                state_q <= ST_LD_SLV;
                            end else begin
                                err_idx_q <= idx_q;
                                state_q   <= ST_FAIL;
                            end
                        end
                    end
                    ST_NEXT: begin
                        retry_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            if (pass_q < LAST_PASS) begin
                                pass_q  <= pass_q + 1'b1;
                                idx_q   <= RESTART;
                                state_q <= ST_LD_SLV;
                            end else begin
                                state_q <= ST_DONE;
                            end
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_LD_SLV;
                        end
                    end
                    ST_DELAY: begin
                        if (dly_q == '0) state_q <= ST_NEXT;
                        else             dly_q   <= dly_q - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tbl_idx       = idx_q;
    assign err_idx       = err_idx_q;
    assign ready         = ready_q;
    assign busy          = busy_q;
    assign error         = error_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_write = write_q;

endmodule
